// File: rtl/ir_fetch_aligner.sv
// Instruction fetch aligner: turns a stream of aligned 32-bit fetch words into
// whole RV32 instructions (16- or 32-bit), expanding compressed ones, with PC
// tracking and flush/restart support.
module ir_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_compressed_o,
  output logic        instr_illegal_o
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  // Buffer occupancy in halfwords doubles as the aligner state.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2,
    StThree = 2'd3
  } count_e;

  count_e      count_q, count_d;
  logic [15:0] hw_q [3];
  logic [15:0] hw_d [3];
  logic [31:0] pc_q, pc_d;
  logic        skip_q, skip_d;
  logic        run_q, run_d;

  logic [15:0] c;
  logic        is_comp;
  logic [31:0] dec_instr;
  logic        dec_illegal;
  logic [4:0]  rs1p, rs2p;
  logic        fire, accept;
  logic [1:0]  cnt_raw, pop_num, n_left, n_new;
  logic        unused_flush_lsb;

  assign unused_flush_lsb = flush_pc_i[0];

  assign c       = hw_q[0];
  assign is_comp = (c[1:0] != 2'b11);
  assign rs1p    = {2'b01, c[9:7]};
  assign rs2p    = {2'b01, c[4:2]};
  assign cnt_raw = count_q;

  assign fetch_ready_o = run_q && (count_q == StEmpty || count_q == StOne) && !flush_i;
  assign instr_valid_o = !flush_i &&
                         ((count_q != StEmpty && is_comp) ||
                          count_q == StTwo || count_q == StThree);

  assign fire   = instr_valid_o && instr_ready_i;
  assign accept = fetch_valid_i && fetch_ready_o;

  assign instr_o            = dec_instr;
  assign instr_pc_o         = pc_q;
  assign instr_compressed_o = is_comp;
  assign instr_illegal_o    = is_comp && dec_illegal;

  // Expand the oldest halfword (RV32C, no FP) or pass a 32-bit instruction through.
  always_comb begin
    dec_instr   = {16'h0000, c};
    dec_illegal = 1'b0;
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: begin
            dec_instr = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rs2p, OpImm};
            if (c[12:5] == 8'h00) dec_illegal = 1'b1;
          end
          3'b010: dec_instr = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rs2p, OpLoad};
          3'b110: dec_instr = {5'b0, c[5], c[12], rs2p, rs1p, 3'b010, c[11:10], c[6], 2'b00,
                               OpStore};
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: dec_instr = {{6{c[12]}}, c[12], c[6:2], c[11:7], 3'b000, c[11:7], OpImm};
          3'b001: dec_instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12],
                               {8{c[12]}}, 5'd1, OpJal};
          3'b010: dec_instr = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, c[11:7], OpImm};
          3'b011: begin
            if (c[11:7] == 5'd2) begin
              dec_instr = {{2{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000,
                           5'd2, OpImm};
            end else begin
              dec_instr = {{14{c[12]}}, c[12], c[6:2], c[11:7], OpLui};
            end
            if ({c[12], c[6:2]} == 6'd0) dec_illegal = 1'b1;
          end
          3'b100: begin
            case (c[11:10])
              2'b00: begin
                dec_instr = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OpImm};
                if (c[12]) dec_illegal = 1'b1;
              end
              2'b01: begin
                dec_instr = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OpImm};
                if (c[12]) dec_illegal = 1'b1;
              end
              2'b10: dec_instr = {{6{c[12]}}, c[12], c[6:2], rs1p, 3'b111, rs1p, OpImm};
              default: begin
                case (c[6:5])
                  2'b00:   dec_instr = {7'b0100000, rs2p, rs1p, 3'b000, rs1p, OpReg};
                  2'b01:   dec_instr = {7'b0000000, rs2p, rs1p, 3'b100, rs1p, OpReg};
                  2'b10:   dec_instr = {7'b0000000, rs2p, rs1p, 3'b110, rs1p, OpReg};
                  default: dec_instr = {7'b0000000, rs2p, rs1p, 3'b111, rs1p, OpReg};
                endcase
                // c[12] set here encodes RV64-only subw/addw.
                if (c[12]) dec_illegal = 1'b1;
              end
            endcase
          end
          3'b101: dec_instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12],
                               {8{c[12]}}, 5'd0, OpJal};
          default: dec_instr = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 2'b00, c[13],
                                c[11:10], c[4:3], c[12], OpBranch};
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: begin
            dec_instr = {7'b0000000, c[6:2], c[11:7], 3'b001, c[11:7], OpImm};
            if (c[12]) dec_illegal = 1'b1;
          end
          3'b010: begin
            dec_instr = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, c[11:7], OpLoad};
            if (c[11:7] == 5'd0) dec_illegal = 1'b1;
          end
          3'b100: begin
            if (!c[12]) begin
              if (c[6:2] == 5'd0) begin
                dec_instr = {12'd0, c[11:7], 3'b000, 5'd0, OpJalr};
                if (c[11:7] == 5'd0) dec_illegal = 1'b1;
              end else begin
                dec_instr = {7'b0000000, c[6:2], 5'd0, 3'b000, c[11:7], OpReg};
              end
            end else if (c[11:2] == 10'd0) begin
              dec_instr = {12'd1, 5'd0, 3'b000, 5'd0, OpSystem};
            end else if (c[6:2] == 5'd0) begin
              dec_instr = {12'd0, c[11:7], 3'b000, 5'd1, OpJalr};
            end else begin
              dec_instr = {7'b0000000, c[6:2], c[11:7], 3'b000, c[11:7], OpReg};
            end
          end
          3'b110: dec_instr = {4'b0000, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00,
                               OpStore};
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_instr = {hw_q[1], c};
    endcase
  end

  // Next state: pop from the pre-push contents, append the accepted word, flush overrides all.
  always_comb begin
    hw_d    = hw_q;
    pc_d    = pc_q;
    skip_d  = skip_q;
    run_d   = 1'b1;
    pop_num = 2'd0;
    if (fire) pop_num = is_comp ? 2'd1 : 2'd2;
    n_left = cnt_raw - pop_num;

    if (fire) begin
      if (is_comp) begin
        hw_d[0] = hw_q[1];
        hw_d[1] = hw_q[2];
        pc_d    = pc_q + 32'd2;
      end else begin
        hw_d[0] = hw_q[2];
        pc_d    = pc_q + 32'd4;
      end
    end

    n_new = n_left;
    // Accept only happens from count <= 1, so n_left is 0 or 1 here.
    if (accept) begin
      if (skip_q) begin
        if (n_left == 2'd0) hw_d[0] = fetch_data_i[31:16];
        else                hw_d[1] = fetch_data_i[31:16];
        n_new  = n_left + 2'd1;
        skip_d = 1'b0;
      end else begin
        if (n_left == 2'd0) begin
          hw_d[0] = fetch_data_i[15:0];
          hw_d[1] = fetch_data_i[31:16];
        end else begin
          hw_d[1] = fetch_data_i[15:0];
          hw_d[2] = fetch_data_i[31:16];
        end
        n_new = n_left + 2'd2;
      end
    end
    count_d = count_e'(n_new);

    if (flush_i) begin
      count_d = StEmpty;
      pc_d    = {flush_pc_i[31:1], 1'b0};
      skip_d  = flush_pc_i[1];
    end
  end

  // State registers; run_q holds fetch_ready_o low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= StEmpty;
      hw_q[0] <= 16'h0000;
      hw_q[1] <= 16'h0000;
      hw_q[2] <= 16'h0000;
      pc_q    <= RESET_PC;
      skip_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      hw_q    <= hw_d;
      pc_q    <= pc_d;
      skip_q  <= skip_d;
      run_q   <= run_d;
    end
  end

endmodule
